// File: rtl/video_sink_if.sv
// ----------------------------------------------------------------------------
// video_sink_if
//
// Purpose:
//    Groups the raster video bus (syncs, display enable and pixel data) that
//    travels from a VGA-style source to the video_sink monitor.
//
// Signals:
//    video_HS     horizontal sync, active low
//    video_VS     vertical sync, active low
//    video_BLANK  display enable: 1 = active pixel, 0 = blanking
//    video_RGB    pixel data {R[7:0],G[7:0],B[7:0]}, valid when BLANK=1
//
// Modports:
//    master  the side that drives the raster (display controller or bench)
//    slave   the side that only observes it (video_sink)
// ----------------------------------------------------------------------------
interface video_sink_if;

   logic        video_HS;
   logic        video_VS;
   logic        video_BLANK;
   logic [23:0] video_RGB;

   modport master (
      output video_HS,
      output video_VS,
      output video_BLANK,
      output video_RGB
   );

   modport slave (
      input video_HS,
      input video_VS,
      input video_BLANK,
      input video_RGB
   );

endinterface

// File: rtl/video_sink.sv
// ----------------------------------------------------------------------------
// video_sink
//
// Purpose:
//    Receiving end of the video raster. Measures the active geometry of each
//    frame, accumulates a per-frame pixel checksum (sum of R+G+B), counts
//    frames and reports lock plus sticky geometry errors. A frame is closed
//    by the falling edge of VS; the first (partial) frame after reset is
//    always discarded.
//
// Pipeline (edges counted from the first edge that samples VS low):
//    E0  input stage S1 captures the bus, S2 holds the previous S1
//    E1  event stage: pixel sum and BLANK/VS edge flags registered
//    E2  frame counters update; on a VS fall the closing frame is
//        snapshotted and the counters restart for the next frame
//    E3  results published, frame_done high for one cycle
//
// Ports:
//    pixel_clk    pixel clock
//    sys_rst      asynchronous, active-high reset
//    vid          video bus (slave modport: HS, VS, BLANK, RGB)
//    clr_err      synchronous clear of the sticky error flags
//    frame_done   one-cycle pulse when a frame's results are published
//    meas_width   active width of the last line of the last frame (sat 4095)
//    meas_height  active line count of the last frame (sat 4095)
//    frame_sum    sum of R+G+B over all active pixels of the last frame
//    frame_cnt    number of published frames, wraps 65535 -> 0
//    locked       LOCK_FRAMES consecutive frames of exactly HDISP x VDISP
//    err_width    sticky: some line width differed from HDISP
//    err_height   sticky: some frame height differed from VDISP
// ----------------------------------------------------------------------------
module video_sink #(
   parameter int HDISP       = 800,
   parameter int VDISP       = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic               pixel_clk,
   input  logic               sys_rst,
   video_sink_if.slave        vid,
   input  logic               clr_err,
   output logic               frame_done,
   output logic [11:0]        meas_width,
   output logic [11:0]        meas_height,
   output logic [31:0]        frame_sum,
   output logic [15:0]        frame_cnt,
   output logic               locked,
   output logic               err_width,
   output logic               err_height
);

   localparam logic [11:0] HDISP_W = 12'(HDISP);
   localparam logic [11:0] VDISP_W = 12'(VDISP);
   localparam logic [3:0]  LOCK_W  = 4'(LOCK_FRAMES);

   typedef enum logic [0:0] {
      SYNC_WAIT = 1'b0,
      RUN       = 1'b1
   } state_t;

   // Input stage S1 and edge-detect stage S2
   logic        s1_hs_q,    s1_hs_d;
   logic        s1_vs_q,    s1_vs_d;
   logic        s1_blank_q, s1_blank_d;
   logic [23:0] s1_rgb_q,   s1_rgb_d;
   logic        s2_vs_q,    s2_vs_d;
   logic        s2_blank_q, s2_blank_d;

   // Event stage
   logic        ev_pix_q,        ev_pix_d;
   logic [9:0]  ev_sum_q,        ev_sum_d;
   logic        ev_blank_fall_q, ev_blank_fall_d;
   logic        ev_vs_fall_q,    ev_vs_fall_d;

   // Frame counters
   state_t      state_q,       state_d;
   logic [11:0] h_cnt_q,       h_cnt_d;
   logic [11:0] v_cnt_q,       v_cnt_d;
   logic [11:0] line_w_q,      line_w_d;
   logic [31:0] acc_q,         acc_d;
   logic        frame_bad_w_q, frame_bad_w_d;

   // Snapshot of the frame being closed, consumed by the publish stage
   logic        pub_req_q,     pub_req_d;
   logic [11:0] snap_w_q,      snap_w_d;
   logic [11:0] snap_h_q,      snap_h_d;
   logic [31:0] snap_sum_q,    snap_sum_d;
   logic        snap_bad_w_q,  snap_bad_w_d;

   // Published results and status
   logic        frame_done_q,  frame_done_d;
   logic [11:0] meas_width_q,  meas_width_d;
   logic [11:0] meas_height_q, meas_height_d;
   logic [31:0] frame_sum_q,   frame_sum_d;
   logic [15:0] frame_cnt_q,   frame_cnt_d;
   logic [3:0]  good_cnt_q,    good_cnt_d;
   logic        locked_q,      locked_d;
   logic        err_width_q,   err_width_d;
   logic        err_height_q,  err_height_d;

   logic        snap_good;

   // Geometry is measured from BLANK alone; HS is sampled with the rest of
   // the bus but has no consumer.
   logic        unused_hs;
   assign unused_hs = s1_hs_q;

   function automatic logic [11:0] sat_inc(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   // Input registers and edge-detect flags. The pixel sum is registered here
   // so the 32-bit accumulate does not sit behind the three-byte adder.
   always_comb begin
      s1_hs_d         = vid.video_HS;
      s1_vs_d         = vid.video_VS;
      s1_blank_d      = vid.video_BLANK;
      s1_rgb_d        = vid.video_RGB;
      s2_vs_d         = s1_vs_q;
      s2_blank_d      = s1_blank_q;
      ev_pix_d        = s1_blank_q;
      ev_sum_d        = {2'b00, s1_rgb_q[23:16]} + {2'b00, s1_rgb_q[15:8]}
                      + {2'b00, s1_rgb_q[7:0]};
      ev_blank_fall_d = s2_blank_q & ~s1_blank_q;
      ev_vs_fall_d    = s2_vs_q & ~s1_vs_q;
   end

   // Frame counters. A line that ends in the same cycle as the VS fall is
   // counted before the frame is snapshotted. A pixel arriving in the VS-fall
   // cycle belongs to the new frame, so it is added after the clear. In
   // SYNC_WAIT nothing is counted until the first VS fall starts a frame.
   always_comb begin
      state_d       = state_q;
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      line_w_d      = line_w_q;
      acc_d         = acc_q;
      frame_bad_w_d = frame_bad_w_q;
      pub_req_d     = 1'b0;
      snap_w_d      = snap_w_q;
      snap_h_d      = snap_h_q;
      snap_sum_d    = snap_sum_q;
      snap_bad_w_d  = snap_bad_w_q;

      if (state_q == RUN && ev_blank_fall_q) begin
         line_w_d = h_cnt_q;
         v_cnt_d  = sat_inc(v_cnt_q);
         h_cnt_d  = 12'd0;
         if (h_cnt_q != HDISP_W) begin
            frame_bad_w_d = 1'b1;
         end
      end

      if (ev_vs_fall_q) begin
         if (state_q == RUN) begin
            pub_req_d    = 1'b1;
            snap_w_d     = line_w_d;
            snap_h_d     = v_cnt_d;
            snap_sum_d   = acc_d;
            snap_bad_w_d = frame_bad_w_d;
         end
         state_d       = RUN;
         h_cnt_d       = 12'd0;
         v_cnt_d       = 12'd0;
         line_w_d      = 12'd0;
         acc_d         = 32'd0;
         frame_bad_w_d = 1'b0;
      end

      if (ev_pix_q && state_d == RUN) begin
         h_cnt_d = sat_inc(h_cnt_d);
         acc_d   = acc_d + 32'(ev_sum_q);
      end
   end

   // Publish stage. clr_err is applied before the new error bits are OR-ed
   // in, so an error raised by this publish survives a coincident clear.
   // Lock and its good-frame counter only move on a publish.
   assign snap_good = !snap_bad_w_q && (snap_h_q == VDISP_W);

   always_comb begin
      frame_done_d  = pub_req_q;
      meas_width_d  = meas_width_q;
      meas_height_d = meas_height_q;
      frame_sum_d   = frame_sum_q;
      frame_cnt_d   = frame_cnt_q;
      good_cnt_d    = good_cnt_q;
      locked_d      = locked_q;
      err_width_d   = clr_err ? 1'b0 : err_width_q;
      err_height_d  = clr_err ? 1'b0 : err_height_q;

      if (pub_req_q) begin
         meas_width_d  = snap_w_q;
         meas_height_d = snap_h_q;
         frame_sum_d   = snap_sum_q;
         frame_cnt_d   = frame_cnt_q + 16'd1;
         err_width_d   = err_width_d | snap_bad_w_q;
         err_height_d  = err_height_d | (snap_h_q != VDISP_W);
         if (snap_good) begin
            good_cnt_d = (good_cnt_q >= LOCK_W) ? LOCK_W : good_cnt_q + 4'd1;
            locked_d   = (good_cnt_d == LOCK_W);
         end else begin
            good_cnt_d = 4'd0;
            locked_d   = 1'b0;
         end
      end
   end

   // State registers; everything returns to zero and SYNC_WAIT on reset.
   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         s1_hs_q         <= 1'b0;
         s1_vs_q         <= 1'b0;
         s1_blank_q      <= 1'b0;
         s1_rgb_q        <= 24'd0;
         s2_vs_q         <= 1'b0;
         s2_blank_q      <= 1'b0;
         ev_pix_q        <= 1'b0;
         ev_sum_q        <= 10'd0;
         ev_blank_fall_q <= 1'b0;
         ev_vs_fall_q    <= 1'b0;
         state_q         <= SYNC_WAIT;
         h_cnt_q         <= 12'd0;
         v_cnt_q         <= 12'd0;
         line_w_q        <= 12'd0;
         acc_q           <= 32'd0;
         frame_bad_w_q   <= 1'b0;
         pub_req_q       <= 1'b0;
         snap_w_q        <= 12'd0;
         snap_h_q        <= 12'd0;
         snap_sum_q      <= 32'd0;
         snap_bad_w_q    <= 1'b0;
         frame_done_q    <= 1'b0;
         meas_width_q    <= 12'd0;
         meas_height_q   <= 12'd0;
         frame_sum_q     <= 32'd0;
         frame_cnt_q     <= 16'd0;
         good_cnt_q      <= 4'd0;
         locked_q        <= 1'b0;
         err_width_q     <= 1'b0;
         err_height_q    <= 1'b0;
      end else begin
         s1_hs_q         <= s1_hs_d;
         s1_vs_q         <= s1_vs_d;
         s1_blank_q      <= s1_blank_d;
         s1_rgb_q        <= s1_rgb_d;
         s2_vs_q         <= s2_vs_d;
         s2_blank_q      <= s2_blank_d;
         ev_pix_q        <= ev_pix_d;
         ev_sum_q        <= ev_sum_d;
         ev_blank_fall_q <= ev_blank_fall_d;
         ev_vs_fall_q    <= ev_vs_fall_d;
         state_q         <= state_d;
         h_cnt_q         <= h_cnt_d;
         v_cnt_q         <= v_cnt_d;
         line_w_q        <= line_w_d;
         acc_q           <= acc_d;
         frame_bad_w_q   <= frame_bad_w_d;
         pub_req_q       <= pub_req_d;
         snap_w_q        <= snap_w_d;
         snap_h_q        <= snap_h_d;
         snap_sum_q      <= snap_sum_d;
         snap_bad_w_q    <= snap_bad_w_d;
         frame_done_q    <= frame_done_d;
         meas_width_q    <= meas_width_d;
         meas_height_q   <= meas_height_d;
         frame_sum_q     <= frame_sum_d;
         frame_cnt_q     <= frame_cnt_d;
         good_cnt_q      <= good_cnt_d;
         locked_q        <= locked_d;
         err_width_q     <= err_width_d;
         err_height_q    <= err_height_d;
      end
   end

   assign frame_done  = frame_done_q;
   assign meas_width  = meas_width_q;
   assign meas_height = meas_height_q;
   assign frame_sum   = frame_sum_q;
   assign frame_cnt   = frame_cnt_q;
   assign locked      = locked_q;
   assign err_width   = err_width_q;
   assign err_height  = err_height_q;

endmodule

// File: tb/tb_video_sink.sv
// ----------------------------------------------------------------------------
// tb_video_sink
//
// Purpose:
//    Self-checking bench for video_sink with a reduced raster (20 x 12) so
//    many frames fit in a short run. Frames are described as a list of line
//    widths; a frame-level reference model derives the expected published
//    results, lock and sticky error state from those widths and the pixel
//    values actually driven.
// ----------------------------------------------------------------------------
module tb_video_sink;

   localparam int HD = 20;
   localparam int VD = 12;
   localparam int LF = 2;

   logic        pixel_clk = 1'b0;
   logic        sys_rst;
   logic        clr_err;
   logic        frame_done;
   logic [11:0] meas_width;
   logic [11:0] meas_height;
   logic [31:0] frame_sum;
   logic [15:0] frame_cnt;
   logic        locked;
   logic        err_width;
   logic        err_height;

   video_sink_if vif ();

   video_sink #(
      .HDISP       (HD),
      .VDISP       (VD),
      .LOCK_FRAMES (LF)
   ) dut (
      .pixel_clk   (pixel_clk),
      .sys_rst     (sys_rst),
      .vid         (vif),
      .clr_err     (clr_err),
      .frame_done  (frame_done),
      .meas_width  (meas_width),
      .meas_height (meas_height),
      .frame_sum   (frame_sum),
      .frame_cnt   (frame_cnt),
      .locked      (locked),
      .err_width   (err_width),
      .err_height  (err_height)
   );

   always #5 pixel_clk = ~pixel_clk;

   int tests_run = 0;
   int fails     = 0;

   // Line widths of the frame about to be sent
   int frame_lines[$];

   // Reference model state
   bit          m_synced;
   int          m_good;
   bit          m_locked;
   bit          m_err_w;
   bit          m_err_h;
   logic [11:0] m_w;
   logic [11:0] m_h;
   logic [31:0] m_sum;
   logic [15:0] m_cnt;

   // One comparison: counts it, asserts it, reports on failure
   task automatic check_output(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                tag, obs, obs, exp, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check_output({tag, ".meas_width"},  32'(meas_width),  32'(m_w));
      check_output({tag, ".meas_height"}, 32'(meas_height), 32'(m_h));
      check_output({tag, ".frame_sum"},   frame_sum,        m_sum);
      check_output({tag, ".frame_cnt"},   32'(frame_cnt),   32'(m_cnt));
      check_output({tag, ".locked"},      32'(locked),      32'(m_locked));
      check_output({tag, ".err_width"},   32'(err_width),   32'(m_err_w));
      check_output({tag, ".err_height"},  32'(err_height),  32'(m_err_h));
   endtask

   task automatic model_reset();
      m_synced = 1'b0;
      m_good   = 0;
      m_locked = 1'b0;
      m_err_w  = 1'b0;
      m_err_h  = 1'b0;
      m_w      = '0;
      m_h      = '0;
      m_sum    = '0;
      m_cnt    = '0;
   endtask

   // Frame-level rules: results of a frame closed by VS; the first frame
   // after reset only establishes sync.
   task automatic model_close_frame(input int n_lines, input int last_w,
                                    input bit bad_w, input longint sum,
                                    input bit clr, output bit published);
      bit good;
      published = m_synced;
      if (clr) begin
         m_err_w = 1'b0;
         m_err_h = 1'b0;
      end
      if (m_synced) begin
         m_w   = 12'(last_w);
         m_h   = 12'(n_lines);
         m_sum = sum[31:0];
         m_cnt = m_cnt + 16'd1;
         m_err_w = m_err_w | bad_w;
         m_err_h = m_err_h | (n_lines != VD);
         good = !bad_w && (n_lines == VD);
         m_good   = good ? ((m_good + 1 > LF) ? LF : m_good + 1) : 0;
         m_locked = (m_good == LF);
      end
      m_synced = 1'b1;
   endtask

   task automatic build_frame(input int n_lines, input int odd_idx,
                              input int odd_w);
      frame_lines.delete();
      for (int i = 0; i < n_lines; i++) frame_lines.push_back(HD);
      if (odd_idx >= 0) frame_lines[odd_idx] = odd_w;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge pixel_clk);
         vif.video_BLANK = 1'b0;
         vif.video_RGB   = 24'd0;
      end
   endtask

   // Drives one frame (lines from frame_lines, then the VS pulse) and checks
   // the publish window. mode: 0 random RGB, 1 24'h010203, 2 24'hFFFFFF.
   // rst_line >= 0 pulses sys_rst for two cycles after that line.
   task automatic apply_stimulus(input string tag, input int mode,
                                 input bit clr_at_pub, input int rst_line);
      longint      sum;
      int          last_w;
      bit          bad_w;
      bit          pub;
      logic [23:0] px;
      sum    = 0;
      last_w = 0;
      bad_w  = 1'b0;
      idle(3);
      foreach (frame_lines[i]) begin
         for (int p = 0; p < frame_lines[i]; p++) begin
            if (mode == 0)      px = 24'($urandom);
            else if (mode == 1) px = 24'h010203;
            else                px = 24'hFFFFFF;
            @(negedge pixel_clk);
            vif.video_BLANK = 1'b1;
            vif.video_RGB   = px;
            sum += longint'(px[23:16]) + longint'(px[15:8]) + longint'(px[7:0]);
         end
         last_w = frame_lines[i];
         if (frame_lines[i] != HD) bad_w = 1'b1;
         @(negedge pixel_clk);
         vif.video_BLANK = 1'b0;
         vif.video_RGB   = 24'd0;
         vif.video_HS    = 1'b0;
         @(negedge pixel_clk);
         @(negedge pixel_clk);
         vif.video_HS    = 1'b1;
         @(negedge pixel_clk);
         if (i == rst_line) begin
            sys_rst = 1'b1;
            #1;
            model_reset();
            check_output({tag, ".rst.frame_done"}, 32'(frame_done), 32'd0);
            check_all({tag, ".rst"});
            @(negedge pixel_clk);
            @(negedge pixel_clk);
            sys_rst = 1'b0;
         end
      end
      idle(2);
      // Vertical sync: VS low for two cycles; frame_done is due on the
      // third edge after the first edge that samples VS low.
      @(negedge pixel_clk);
      vif.video_VS = 1'b0;
      @(negedge pixel_clk);
      @(negedge pixel_clk);
      vif.video_VS = 1'b1;
      @(negedge pixel_clk);
      check_output({tag, ".early_done"}, 32'(frame_done), 32'd0);
      if (clr_at_pub) clr_err = 1'b1;
      @(negedge pixel_clk);
      clr_err = 1'b0;
      model_close_frame(frame_lines.size(), last_w, bad_w, sum, clr_at_pub, pub);
      check_output({tag, ".frame_done"}, 32'(frame_done), 32'(pub));
      check_all(tag);
      @(negedge pixel_clk);
      check_output({tag, ".done_pulse"}, 32'(frame_done), 32'd0);
   endtask

   task automatic pulse_clr(input string tag);
      @(negedge pixel_clk);
      clr_err = 1'b1;
      @(negedge pixel_clk);
      clr_err = 1'b0;
      m_err_w = 1'b0;
      m_err_h = 1'b0;
      check_output({tag, ".err_width"},  32'(err_width),  32'(m_err_w));
      check_output({tag, ".err_height"}, 32'(err_height), 32'(m_err_h));
   endtask

   initial begin
      sys_rst         = 1'b1;
      clr_err         = 1'b0;
      vif.video_HS    = 1'b1;
      vif.video_VS    = 1'b1;
      vif.video_BLANK = 1'b0;
      vif.video_RGB   = 24'd0;
      model_reset();

      // Reset state
      @(negedge pixel_clk);
      @(negedge pixel_clk);
      check_output("reset.frame_done", 32'(frame_done), 32'd0);
      check_all("reset");
      sys_rst = 1'b0;

      // Partial first frame is discarded, then three good constant frames
      build_frame(VD, -1, 0);
      apply_stimulus("sync", 1, 1'b0, -1);
      apply_stimulus("const1", 1, 1'b0, -1);
      apply_stimulus("const2", 1, 1'b0, -1);
      apply_stimulus("const3", 1, 1'b0, -1);

      // One short line breaks lock and sets the sticky width error
      build_frame(VD, int'($urandom_range(0, VD - 1)), HD - 1);
      apply_stimulus("short_line", 0, 1'b0, -1);
      build_frame(VD, -1, 0);
      apply_stimulus("relock1", 0, 1'b0, -1);
      apply_stimulus("relock2", 0, 1'b0, -1);
      pulse_clr("clr_w");

      // Short frame
      build_frame(VD - 1, -1, 0);
      apply_stimulus("short_frame", 0, 1'b0, -1);

      // Full-scale pixels
      build_frame(VD, -1, 0);
      apply_stimulus("white", 2, 1'b0, -1);

      // Clear coinciding with a publish that raises err_height
      pulse_clr("clr_h");
      build_frame(VD - 1, -1, 0);
      apply_stimulus("clr_vs_set", 0, 1'b1, -1);

      // Frame with no active lines
      build_frame(0, -1, 0);
      apply_stimulus("empty", 0, 1'b0, -1);

      // Reset mid-frame: that frame is discarded, the next one publishes
      build_frame(VD, -1, 0);
      apply_stimulus("mid_reset", 0, 1'b0, 4);
      apply_stimulus("post_reset", 0, 1'b0, -1);

      // Frame counter wrap
      @(negedge pixel_clk);
      dut.frame_cnt_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      apply_stimulus("wrap", 0, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/video_sink.md
Name: video_sink

Overview:
- Receiving end of the video interface. It is the counterpart of the VGA controller that drives the display.
- Samples HS/VS/BLANK/RGB on pixel_clk and measures the active frame geometry against HDISP/VDISP.
- Accumulates a per-frame pixel checksum, counts frames, and reports lock and sticky error status.
- Used in simulation benches and on-chip as a loopback monitor of the video output.

Parameters:
- HDISP, 800, expected active pixels per line
- VDISP, 480, expected active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required before lock asserts (1..15)

Ports:
- pixel_clk  in  1  pixel clock
- sys_rst  in  1  reset; asynchronous, active-high (decided)
- video_HS  in  1  horizontal sync, active low
- video_VS  in  1  vertical sync, active low
- video_BLANK  in  1  display enable: 1 = active pixel, 0 = blanking
- video_RGB  in  24  pixel data {R[7:0],G[7:0],B[7:0]}, valid when BLANK=1
- clr_err  in  1  synchronous clear of sticky error flags
- frame_done  out  1  one-cycle pulse when a complete frame's results are published
- meas_width  out  12  active width of last line of last frame, saturating at 4095
- meas_height  out  12  active line count of last frame, saturating at 4095
- frame_sum  out  32  sum of R+G+B over all active pixels of last frame, mod 2^32
- frame_cnt  out  16  number of completed frames, wraps 65535->0
- locked  out  1  geometry stable at HDISP x VDISP
- err_width  out  1  sticky: some line width != HDISP
- err_height  out  1  sticky: some frame height != VDISP

Behaviour:
- Reset values: all outputs 0; FSM in SYNC_WAIT; all internal counters and the accumulator 0.
- Input stage:
  - All video inputs registered once (stage S1), plus a second register (S2) for edge detection.
  - VS fall = S2.VS=1 and S1.VS=0.
  - BLANK rise/fall defined likewise.
- FSM:
  - SYNC_WAIT: ignores pixels; on VS fall -> RUN. Counters cleared, no frame_done. The partial first frame is discarded.
  - RUN: accumulate. On VS fall, publish, clear counters, stay in RUN.
- Per pixel in RUN (S1.BLANK=1):
  - h_cnt += 1, saturating at 4095.
  - acc += R+G+B, with R+G+B zero-extended to 10 bits and acc mod 2^32.
- On BLANK fall in RUN:
  - line_w <= h_cnt; v_cnt += 1 (saturating 4095); h_cnt <= 0.
  - If h_cnt != HDISP, set frame_bad_w.
- Line ending exactly at the VS fall: a BLANK fall and a VS fall in the same cycle count the line first, then publish.
- Publish, in the cycle after the VS fall is detected:
  - Pulse frame_done for 1 cycle.
  - meas_width <= line_w; meas_height <= v_cnt; frame_sum <= acc; frame_cnt += 1.
  - err_width |= frame_bad_w; err_height |= (v_cnt != VDISP).
- Publish latency: frame_done is high 3 pixel_clk edges after the first edge that samples video_VS low.
- Pixels with BLANK=1 while VS is low are still accumulated, into the next frame.
- Lock logic:
  - good = !frame_bad_w && v_cnt == VDISP.
  - good_cnt increments on each good publish, saturating at LOCK_FRAMES.
  - locked = 1 when good_cnt == LOCK_FRAMES; it updates in the same cycle as frame_done.
  - Any bad publish: good_cnt <= 0 and locked <= 0 in that cycle.
- clr_err clears err_width/err_height next cycle. If clr_err coincides with a publish that sets an error, set wins.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). The next frame after reset is always discarded, via SYNC_WAIT.
- A frame with zero active lines publishes meas_width=0, meas_height=0, frame_sum=0 and counts as bad.

Test Plan:
- Reset then 3 frames of 800x480 with constant RGB=24'h010203 -> no frame_done for the partial first frame, then frame_done on each VS. frame_sum=384000*6=2304000, meas_width=800, meas_height=480, locked=1 after 2nd published frame, errors 0.
- Locked stream, one frame with a single line 799 px wide -> at that publish err_width=1, locked=0. Next frame meas_width=800; locked back to 1 after 2 good frames. err_width stays 1 until clr_err pulse, then 0.
- Frame of 479 lines -> meas_height=479, err_height=1, locked=0, frame_cnt still increments.
- RGB=24'hFFFFFF for 800x480 -> frame_sum = 384000*765 mod 2^32 = 293760000, checking wide accumulation.
- Assert sys_rst mid-frame for 2 cycles -> all outputs 0 immediately. The following frame is not published; frame_cnt=1 after the second VS post-reset.
- clr_err asserted in the same cycle as a publish setting err_height -> err_height=1 afterwards. Separately, force frame_cnt to wrap from 65535 -> 0.
